// File: rtl/cpu_bus_pkg.sv
// Shared types for the CPU bus controller: FSM states, the interrupt-acknowledge
// function code and the latched bus-cycle record.
package cpu_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    DLY,
    ACK,
    IACK,
    ABORT,
    FAULT
  } state_t;

  localparam logic [2:0] FC_IACK = 3'b111;

  typedef struct packed {
    logic [22:0] addr;
    logic        we;
    logic [1:0]  be;
    logic [15:0] wdata;
  } bus_cycle_t;

  function automatic bus_cycle_t make_cycle(input logic [22:0] word_addr,
                                            input logic        rw_n,
                                            input logic        uds_n,
                                            input logic        lds_n,
                                            input logic [15:0] dout);
    bus_cycle_t c;
    c.addr  = word_addr;
    c.we    = ~rw_n;
    c.be    = {~uds_n, ~lds_n};
    c.wdata = dout;
    return c;
  endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// CPU-side and memory-side signal bundle of the bus controller.
// master = the controller itself, slave = the CPU/memory environment around it.
interface cpu_bus_ctrl_if;
  logic        AS_n;
  logic        UDS_n;
  logic        LDS_n;
  logic        rw_n;
  logic [23:0] address;
  logic [2:0]  FC;
  logic [15:0] cpu_dout;
  logic        dTACK_n;
  logic [15:0] cpu_din;
  logic        buserr;
  logic        iack;
  logic [2:0]  iack_level;
  logic        mem_req;
  logic        mem_we;
  logic [22:0] mem_addr;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    input  AS_n, UDS_n, LDS_n, rw_n, address, FC, cpu_dout, mem_ack, mem_rdata,
    output dTACK_n, cpu_din, buserr, iack, iack_level,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output AS_n, UDS_n, LDS_n, rw_n, address, FC, cpu_dout, mem_ack, mem_rdata,
    input  dTACK_n, cpu_din, buserr, iack, iack_level,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/bus_timeout_cnt.sv
// Saturating cycle counter with synchronous clear, enable and terminal-count flag.
module bus_timeout_cnt #(
  parameter int unsigned MAX = 1023
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)         cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (en && !tc)   cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == W'(MAX));
endmodule

// File: rtl/cpu_bus_ctrl.sv
// 68k-style asynchronous CPU bus to single-request memory port bridge.
// Define CPU_BUS_TIMEOUT_EN to enable the mem_ack timeout / bus error path.
module cpu_bus_ctrl
  import cpu_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1023,
  parameter int unsigned DTACK_DLY   = 0
) (
  input logic            clk,
  input logic            reset_n,
  cpu_bus_ctrl_if.master bus
);
  localparam int unsigned DLY_W = (DTACK_DLY > 1) ? $clog2(DTACK_DLY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((DTACK_DLY > 0) ? DTACK_DLY - 1 : 0);

  state_t           state;
  bus_cycle_t       cyc;
  logic             mem_req_q;
  logic             dtack_n_q;
  logic [15:0]      cpu_din_q;
  logic             iack_q;
  logic [2:0]       iack_level_q;
  logic [DLY_W-1:0] dly_cnt;
  logic             timeout;
  logic             rst_meta;
  logic             rst_n;
  logic             addr0_unused;

  assign addr0_unused = bus.address[0];

  // Assertion is immediate; release reaches the FSM two clk edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) {rst_n, rst_meta} <= 2'b00;
    else          {rst_n, rst_meta} <= {rst_meta, 1'b1};
  end

`ifdef CPU_BUS_TIMEOUT_EN
  bus_timeout_cnt #(.MAX(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .reset_n (rst_n),
    .clr     (state != REQ),
    .en      (state == REQ),
    .tc      (timeout)
  );
  assign bus.buserr = (state == FAULT);
`else
  // TIMEOUT_CYC is kept on the port list so both builds share one interface.
  assign timeout    = 1'b0 & (TIMEOUT_CYC == 0);
  assign bus.buserr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cyc          <= '0;
      mem_req_q    <= 1'b0;
      dtack_n_q    <= 1'b1;
      cpu_din_q    <= '0;
      iack_q       <= 1'b0;
      iack_level_q <= '0;
      dly_cnt      <= '0;
    end else begin
      iack_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!bus.AS_n) begin
            if (bus.FC == FC_IACK) begin
              state        <= IACK;
              iack_q       <= 1'b1;
              iack_level_q <= bus.address[3:1];
            end else if (!(bus.UDS_n & bus.LDS_n)) begin
              state <= REQ;
              cyc   <= make_cycle(bus.address[23:1], bus.rw_n, bus.UDS_n,
                                  bus.LDS_n, bus.cpu_dout);
            end
          end
        end
        // Ack wins over a simultaneous AS_n release so the transaction is
        // never lost; an abort before mem_req rose has nothing to drain.
        REQ: begin
          if (mem_req_q && bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (!cyc.we) cpu_din_q <= bus.mem_rdata;
            if (bus.AS_n) begin
              state <= IDLE;
            end else if (DTACK_DLY == 0) begin
              state     <= ACK;
              dtack_n_q <= 1'b0;
            end else begin
              state   <= DLY;
              dly_cnt <= '0;
            end
          end else if (bus.AS_n) begin
            state <= mem_req_q ? ABORT : IDLE;
          end else if (timeout) begin
            mem_req_q <= 1'b0;
            state     <= FAULT;
          end else begin
            mem_req_q <= 1'b1;
          end
        end
        DLY: begin
          if (bus.AS_n) begin
            state <= IDLE;
          end else if (dly_cnt == DLY_LAST) begin
            state     <= ACK;
            dtack_n_q <= 1'b0;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        ACK: begin
          if (bus.AS_n) begin
            state     <= IDLE;
            dtack_n_q <= 1'b1;
          end
        end
        IACK: begin
          if (bus.AS_n) state <= IDLE;
        end
        ABORT: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= IDLE;
          end
        end
        FAULT: begin
          if (bus.AS_n) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = cyc.we;
  assign bus.mem_addr   = cyc.addr;
  assign bus.mem_be     = cyc.be;
  assign bus.mem_wdata  = cyc.wdata;
  assign bus.dTACK_n    = dtack_n_q;
  assign bus.cpu_din    = cpu_din_q;
  assign bus.iack       = iack_q;
  assign bus.iack_level = iack_level_q;
endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Self-checking bench for cpu_bus_ctrl: randomized CPU/memory cycles against a
// timeline model of when each output must change.
module tb_cpu_bus_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [15:0] exp_din;
  logic [2:0]  exp_lvl;

  cpu_bus_ctrl_if bus ();

  cpu_bus_ctrl #(.TIMEOUT_CYC(TO), .DTACK_DLY(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input bit after_reset);
    check({tag, ".mem_req"}, 32'(bus.mem_req), 32'(0));
    check({tag, ".dtack_n"}, 32'(bus.dTACK_n), 32'(1));
    check({tag, ".buserr"},  32'(bus.buserr), 32'(0));
    check({tag, ".iack"},    32'(bus.iack), 32'(0));
    check({tag, ".cpu_din"}, 32'(bus.cpu_din), 32'(exp_din));
    check({tag, ".iack_lvl"}, 32'(bus.iack_level), 32'(exp_lvl));
    if (after_reset) begin
      check({tag, ".mem_we"},    32'(bus.mem_we), 32'(0));
      check({tag, ".mem_addr"},  32'(bus.mem_addr), 32'(0));
      check({tag, ".mem_be"},    32'(bus.mem_be), 32'(0));
      check({tag, ".mem_wdata"}, 32'(bus.mem_wdata), 32'(0));
    end
  endtask

  // Tick t = t-th clk edge after AS_n is driven low. The request appears at
  // tick 2, memory acks so that edge a samples it, the CPU releases AS_n so
  // that edge rel+1 samples it.
  task automatic bus_cycle(input logic [23:0] addr, input logic rw, input logic [1:0] be,
                           input logic [15:0] wd, input logic [15:0] rd,
                           input int ack_dly, input int rel, input bit wiggle);
    int a;
    int last;
    bit completes;
    a         = 3 + ack_dly;
    last      = ((a > rel + 1) ? a : rel + 1) + 1;
    completes = (a <= rel + 1);
    bus.address  = addr;
    bus.rw_n     = rw;
    bus.UDS_n    = ~be[1];
    bus.LDS_n    = ~be[0];
    bus.cpu_dout = wd;
    bus.FC       = 3'($urandom_range(0, 6));
    bus.mem_ack  = 1'b0;
    bus.AS_n     = 1'b0;
    for (int t = 1; t <= last; t++) begin
      tick();
      if (t == a && rw && completes) exp_din = rd;
      check("mem_req", 32'(bus.mem_req), 32'(t >= 2 && t < a));
      check("dtack_n", 32'(bus.dTACK_n), 32'(!(a <= rel && t >= a && t <= rel)));
      check("cpu_din", 32'(bus.cpu_din), 32'(exp_din));
      check("iack", 32'(bus.iack), 32'(0));
      check("iack_lvl", 32'(bus.iack_level), 32'(exp_lvl));
      check("buserr", 32'(bus.buserr), 32'(0));
      if (t >= 2 && t < a) begin
        check("mem_addr", 32'(bus.mem_addr), 32'(addr >> 1));
        check("mem_be", 32'(bus.mem_be), 32'(be));
        check("mem_we", 32'(bus.mem_we), 32'(!rw));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(wd));
      end
      bus.mem_ack   = (t == a - 1);
      bus.mem_rdata = (t == a - 1) ? rd : 16'($urandom);
      if (t >= rel) bus.AS_n = 1'b1;
      if (wiggle && t == 3) begin
        bus.UDS_n = 1'($urandom);
        bus.LDS_n = 1'($urandom);
      end
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic iack_cycle(input logic [2:0] lvl);
    bus.address  = {20'($urandom), lvl, 1'b0};
    bus.FC       = 3'b111;
    bus.rw_n     = 1'b1;
    bus.UDS_n    = 1'($urandom);
    bus.LDS_n    = 1'($urandom);
    bus.mem_ack  = 1'b0;
    bus.AS_n     = 1'b0;
    for (int t = 1; t <= 5; t++) begin
      tick();
      exp_lvl = lvl;
      check("iack_pulse", 32'(bus.iack), 32'(t == 1));
      check("iack_level", 32'(bus.iack_level), 32'(lvl));
      check("iack_mem_req", 32'(bus.mem_req), 32'(0));
      check("iack_dtack_n", 32'(bus.dTACK_n), 32'(1));
      if (t == 3) bus.AS_n = 1'b1;
    end
  endtask

  task automatic stray_ack();
    bus.AS_n      = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'($urandom);
    tick();
    bus.mem_ack = 1'b0;
    tick();
    check_idle("stray_ack", 1'b0);
  endtask

`ifdef CPU_BUS_TIMEOUT_EN
  task automatic timeout_cycle();
    int rel;
    rel = 2 + TO + 3;
    bus.address  = 24'h00_4000;
    bus.rw_n     = 1'b1;
    bus.UDS_n    = 1'b0;
    bus.LDS_n    = 1'b0;
    bus.FC       = 3'b101;
    bus.mem_ack  = 1'b0;
    bus.AS_n     = 1'b0;
    for (int t = 1; t <= rel + 3; t++) begin
      tick();
      check("to_mem_req", 32'(bus.mem_req), 32'(t >= 2 && t < 2 + TO));
      check("to_buserr", 32'(bus.buserr), 32'(t >= 2 + TO && t <= rel));
      check("to_dtack_n", 32'(bus.dTACK_n), 32'(1));
      check("to_cpu_din", 32'(bus.cpu_din), 32'(exp_din));
      bus.mem_ack   = (t == rel + 1);
      bus.mem_rdata = 16'hDEAD;
      if (t >= rel) bus.AS_n = 1'b1;
    end
    bus.mem_ack = 1'b0;
  endtask
`endif

  task automatic reset_mid_cycle();
    bus.address = 24'h00_2000;
    bus.rw_n    = 1'b1;
    bus.UDS_n   = 1'b0;
    bus.LDS_n   = 1'b0;
    bus.FC      = 3'b010;
    bus.mem_ack = 1'b0;
    bus.AS_n    = 1'b0;
    repeat (3) tick();
    check("rst_pre_mem_req", 32'(bus.mem_req), 32'(1));
    #2 reset_n = 1'b0;
    #1;
    exp_din = '0;
    exp_lvl = '0;
    check_idle("rst_mid", 1'b1);
    tick();
    bus.AS_n      = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hBEEF;
    tick();
    bus.mem_ack = 1'b0;
    reset_n     = 1'b1;
    repeat (3) tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    check_idle("rst_late_ack", 1'b1);
  endtask

  initial begin
    int a;
    int ack_dly;
    logic rw;
    bus.AS_n      = 1'b1;
    bus.UDS_n     = 1'b1;
    bus.LDS_n     = 1'b1;
    bus.rw_n      = 1'b1;
    bus.address   = '0;
    bus.FC        = '0;
    bus.cpu_dout  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    exp_din       = '0;
    exp_lvl       = '0;

    repeat (3) tick();
    check_idle("reset", 1'b1);
    reset_n = 1'b1;
    repeat (3) tick();
    check_idle("post_reset", 1'b1);

    bus_cycle(24'h00FC00, 1'b1, 2'b11, 16'h5A5A, 16'h1234, 5, 10, 1'b0);
    check("word_read_din", 32'(bus.cpu_din), 32'h1234);
    bus_cycle(24'h000001, 1'b0, 2'b01, 16'h00AB, 16'hFFFF, 3, 8, 1'b1);
    iack_cycle(3'd6);
    bus_cycle(24'h123456, 1'b0, 2'b10, 16'hC3C3, 16'h0000, 8, 4, 1'b0);
    bus_cycle(24'h0ABCDE, 1'b1, 2'b11, 16'h0000, 16'h8001, 2, 6, 1'b0);
    bus_cycle(24'h00F00E, 1'b1, 2'b10, 16'h0000, 16'h7E57, 3, 5, 1'b0);
    stray_ack();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0: iack_cycle(3'($urandom));
        1: stray_ack();
        2: begin
          ack_dly = int'($urandom_range(1, 8));
          a       = 3 + ack_dly;
          bus_cycle(24'($urandom), 1'b0, 2'($urandom_range(1, 3)), 16'($urandom),
                    16'($urandom), ack_dly, int'($urandom_range(2, a - 1)), 1'($urandom));
        end
        default: begin
          ack_dly = int'($urandom_range(0, 8));
          a       = 3 + ack_dly;
          rw      = 1'($urandom);
          bus_cycle(24'($urandom), rw, 2'($urandom_range(1, 3)), 16'($urandom),
                    16'($urandom), ack_dly, a + int'($urandom_range(0, 3)), 1'($urandom));
        end
      endcase
    end

`ifdef CPU_BUS_TIMEOUT_EN
    timeout_cycle();
`endif

    reset_mid_cycle();
    bus_cycle(24'h000100, 1'b1, 2'b11, 16'h0000, 16'hA5A5, 1, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/cpu_bus_ctrl.md
CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 1023: clk cycles waiting for mem_ack before a bus error is raised.
REQ-002 Parameter DTACK_DLY, default 0: extra clk cycles between mem_ack and dTACK_n assertion.
REQ-003 Port clk, input, 1: system clock, 2x CPU rate.
REQ-004 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 Ports from the CPU side, all inputs: AS_n 1, UDS_n 1, LDS_n 1, rw_n 1, address 24, FC 3, cpu_dout 16.
REQ-006 Ports to the CPU side, all outputs: dTACK_n 1, cpu_din 16, buserr 1, iack 1 (one-cycle pulse), iack_level 3.
REQ-007 Memory ports, outputs: mem_req 1, mem_we 1, mem_addr 23 (A23:A1), mem_be 2 ({~UDS_n,~LDS_n}), mem_wdata 16.
REQ-008 Memory ports, inputs: mem_ack 1 (one-cycle pulse), mem_rdata 16.

Function
REQ-009 States: IDLE, REQ, DLY, ACK, IACK, ABORT, FAULT.
REQ-010 IDLE -> REQ when AS_n=0, (UDS_n & LDS_n)=0 and FC!=3'b111; the same edge latches address, rw_n, strobes and cpu_dout.
REQ-011 IDLE -> IACK when AS_n=0 and FC=3'b111.
REQ-012 In IACK: iack pulses high for exactly 1 cycle; iack_level <= address[3:1]; no mem_req is issued; dTACK_n stays 1; state -> IDLE when AS_n=1.
REQ-013 mem_req rises 1 cycle after the IDLE->REQ transition; mem_req, mem_we (= ~rw_n latched), mem_addr, mem_be and mem_wdata stay stable until the cycle mem_ack=1.
REQ-014 On mem_ack in REQ: mem_req <= 0; on reads, cpu_din <= mem_rdata; state -> DLY, or -> ACK directly when DTACK_DLY=0.
REQ-015 DLY counts DTACK_DLY cycles, then -> ACK.
REQ-016 In ACK: dTACK_n=0 until AS_n=1 is sampled; that edge sets dTACK_n=1 and state -> IDLE.
REQ-017 No new cycle may start in the cycle AS_n rises; a minimum of 1 IDLE cycle separates consecutive bus cycles.
REQ-018 AS_n=1 while in REQ (aborted cycle) -> ABORT: mem_req is held until mem_ack, then -> IDLE without asserting dTACK_n; a memory transaction is never orphaned.
REQ-019 mem_ack arriving in the same cycle AS_n rises: the transaction completes, cpu_din is updated, state -> IDLE, dTACK_n is not asserted.
REQ-020 A mem_ack received outside REQ/ABORT is ignored.
REQ-021 A strobe change after the cycle is latched does not alter mem_be.

Reset
REQ-022 When reset_n=0 (asynchronous): state=IDLE, dTACK_n=1, buserr=0, iack=0, iack_level=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, cpu_din=0, counters=0.
REQ-023 Reset in the middle of a cycle drops mem_req immediately; any subsequent mem_ack is ignored per REQ-020.
REQ-024 Release of reset is synchronised to clk; the first cycle can start 2 clks after release.

Configuration
REQ-025 Macro CPU_BUS_TIMEOUT_EN defined: a counter increments in REQ each clk and clears on entering REQ.
REQ-026 When the counter reaches TIMEOUT_CYC: mem_req <= 0, buserr <= 1, state -> FAULT.
REQ-027 FAULT holds buserr=1 and dTACK_n=1 until AS_n=1, then -> IDLE with buserr=0; a late mem_ack is ignored.
REQ-028 Macro undefined: no counter; buserr is tied to 0; FAULT is unreachable; REQ waits for mem_ack indefinitely.

Structure
REQ-029 Shared package cpu_bus_pkg holds: the state enum, FC_IACK=3'b111, and the bus-cycle typedef {addr, we, be, wdata}.
REQ-030 Sub-module bus_timeout_cnt (counter with clear, enable and terminal-count flag) is instantiated only under CPU_BUS_TIMEOUT_EN.

Verification
REQ-031 Word read at 0x00FC00 with mem_ack after 5 clks, rdata=0x1234 -> mem_addr=0x7E00, mem_be=2'b11, cpu_din=0x1234, dTACK_n low 1 clk after ack, high 1 clk after AS_n rises.
REQ-032 Byte write of 0x00AB at 0x000001 (LDS only) -> mem_we=1, mem_be=2'b01, mem_wdata=0x00AB, single mem_req until ack.
REQ-033 FC=111 with address[3:1]=6 -> iack single pulse, iack_level=6, no mem_req, dTACK_n stays 1.
REQ-034 AS_n rises 2 clks after mem_req with ack at +8 -> mem_req is held to the ack, dTACK_n is never asserted, and the next cycle proceeds normally.
REQ-035 CPU_BUS_TIMEOUT_EN defined, TIMEOUT_CYC=16, no ack -> buserr=1 at cycle 16, mem_req=0, buserr clears after AS_n rises.
REQ-036 Reset_n pulsed low during REQ -> all outputs at reset values in the same cycle; a late ack is ignored.
